tsp_tour_checker: RTL and testbench

- Consumer end of the solver's output interface: reads the city coordinate arrays (xs, ys) and the tour array (path) produced by the tsp block.
- On request, snapshots the tour and walks it one edge per cycle.
- Reports the closed-tour Manhattan length and whether path is a valid permutation of the cities.
- Used on-chip to score the solver's current best tour while the solver keeps running, and by benches as a self-check.

---
 rtl/tsp_tour_checker_if.sv | 28 ++
 rtl/tsp_tour_checker.sv | 133 +++++++++++++
 tb/tb_tsp_tour_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsp_tour_checker_if.sv
// Bundle between the tour checker and whoever requests an evaluation.
// start is a request sampled only while the checker is idle; done is a one-cycle completion pulse; there is no backpressure.
interface tsp_tour_checker_if #(
    parameter int N      = 64,
    parameter int IDXW   = 6,
    parameter int COORDW = 8,
    parameter int LENW   = 16
);
    logic [COORDW-1:0] xs   [N];
    logic [COORDW-1:0] ys   [N];
    logic [IDXW-1:0]   path [N];
    logic              start;
    logic              busy;
    logic              done;
    logic [LENW-1:0]   tour_len;
    logic              tour_valid;
    logic [IDXW-1:0]   dup_city;

    modport master (
        output xs, ys, path, start,
        input  busy, done, tour_len, tour_valid, dup_city
    );

    modport slave (
        input  xs, ys, path, start,
        output busy, done, tour_len, tour_valid, dup_city
    );
endinterface

// File: rtl/tsp_tour_checker.sv
// Snapshots a TSP tour and walks it one edge per cycle, reporting the closed
// Manhattan length and whether the tour is a permutation of all cities.
module tsp_tour_checker #(
    parameter int N      = 64,
    parameter int IDXW   = 6,
    parameter int COORDW = 8,
    parameter int LENW   = 16
) (
    input  logic                clk,
    input  logic                rst,
    tsp_tour_checker_if.slave   bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COORDW-1:0] snap_x    [N];
    logic [COORDW-1:0] snap_y    [N];
    logic [IDXW-1:0]   snap_path [N];
    logic [N-1:0]      seen;
    logic [LENW-1:0]   acc;
    logic [IDXW-1:0]   idx_q;
    logic              dup_flag;
    logic [IDXW-1:0]   dup_city_r;

    logic [LENW-1:0]   tour_len_q;
    logic              tour_valid_q;
    logic [IDXW-1:0]   dup_city_q;
    logic              done_q;

    logic [IDXW-1:0]   nxt_idx;
    logic [IDXW-1:0]   city_a, city_b;
    logic [COORDW-1:0] xa, xb, ya, yb, dx, dy;
    logic [LENW-1:0]   edge_len;

    assign state_dbg      = state_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.tour_len   = tour_len_q;
    assign bus.tour_valid = tour_valid_q;
    assign bus.dup_city   = dup_city_q;

    // N is a power of two, so the index increment wraps to close the tour.
    assign nxt_idx = idx_q + 1'b1;
    assign city_a  = snap_path[idx_q];
    assign city_b  = snap_path[nxt_idx];
    assign xa      = snap_x[city_a];
    assign xb      = snap_x[city_b];
    assign ya      = snap_y[city_a];
    assign yb      = snap_y[city_b];

    always_comb begin
        dx       = (xa >= xb) ? (xa - xb) : (xb - xa);
        dy       = (ya >= yb) ? (ya - yb) : (yb - ya);
        edge_len = LENW'(dx) + LENW'(dy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == IDXW'(N - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                snap_x[k]    <= '0;
                snap_y[k]    <= '0;
                snap_path[k] <= '0;
            end
            seen         <= '0;
            acc          <= '0;
            idx_q        <= '0;
            dup_flag     <= 1'b0;
            dup_city_r   <= '0;
            tour_len_q   <= '0;
            tour_valid_q <= 1'b0;
            dup_city_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N; k++) begin
                            snap_x[k]    <= bus.xs[k];
                            snap_y[k]    <= bus.ys[k];
                            snap_path[k] <= bus.path[k];
                        end
                        seen       <= '0;
                        acc        <= '0;
                        idx_q      <= '0;
                        dup_flag   <= 1'b0;
                        dup_city_r <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc + edge_len;
                    idx_q <= nxt_idx;
                    // Only the first repeated city is reported.
                    if (seen[city_a] && !dup_flag) begin
                        dup_flag   <= 1'b1;
                        dup_city_r <= city_a;
                    end
                    seen[city_a] <= 1'b1;
                end
                DONE: begin
                    tour_len_q   <= acc;
                    tour_valid_q <= ~dup_flag;
                    dup_city_q   <= dup_flag ? dup_city_r : '0;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tsp_tour_checker.sv
// Randomized bench for tsp_tour_checker: results are compared against a
// tour-level model that sums edge distances and looks for repeated cities.
module tb_tsp_tour_checker;

    localparam int N      = 64;
    localparam int IDXW   = 6;
    localparam int COORDW = 8;
    localparam int LENW   = 16;
    localparam int RW     = LENW + 1 + IDXW;
    localparam int BUDGET = 200;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    tsp_tour_checker_if #(.N(N), .IDXW(IDXW), .COORDW(COORDW), .LENW(LENW)) bus ();

    tsp_tour_checker #(.N(N), .IDXW(IDXW), .COORDW(COORDW), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    int m_x [N];
    int m_y [N];
    int m_p [N];

    logic [RW-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [RW-1:0] model_result();
        int len;
        bit valid;
        int dup;
        bit seen [N];
        len   = 0;
        valid = 1'b1;
        dup   = 0;
        for (int k = 0; k < N; k++) seen[k] = 1'b0;
        for (int i = 0; i < N; i++) begin
            int a;
            int b;
            a = m_p[i];
            b = m_p[(i + 1) % N];
            len += iabs(m_x[a] - m_x[b]) + iabs(m_y[a] - m_y[b]);
            if (seen[a] && valid) begin
                valid = 1'b0;
                dup   = a;
            end
            seen[a] = 1'b1;
        end
        return {LENW'(len), valid, IDXW'(dup)};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {bus.tour_len, bus.tour_valid, bus.dup_city};
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.xs[i]   = COORDW'(m_x[i]);
            bus.ys[i]   = COORDW'(m_y[i]);
            bus.path[i] = IDXW'(m_p[i]);
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < N; i++) begin
            m_x[i] = i;
            m_y[i] = i;
            m_p[i] = i;
        end
    endtask

    task automatic set_random(input bit allow_dups);
        for (int i = 0; i < N; i++) begin
            m_x[i] = $urandom_range(0, (1 << COORDW) - 1);
            m_y[i] = $urandom_range(0, (1 << COORDW) - 1);
            m_p[i] = i;
        end
        for (int i = N - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = m_p[i];
            m_p[i] = m_p[j];
            m_p[j] = t;
        end
        if (allow_dups) begin
            int cnt;
            cnt = $urandom_range(1, 4);
            for (int k = 0; k < cnt; k++) m_p[$urandom_range(0, N - 1)] = $urandom_range(0, N - 1);
        end
    endtask

    // Pulses start (edge T) and waits at negedges; cyc counts edges after T.
    task automatic start_and_wait(output int cyc, output bit ok, output bit busy_ok);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        ok = 1'b0;
        busy_ok = 1'b1;
        while (cyc < BUDGET) begin
            if (bus.done) begin
                ok = 1'b1;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        set_identity();
        apply();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.tour_len, bus.tour_valid, bus.dup_city, state_dbg} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b len=%0d valid=%b dup=%0d state=%0d required all 0",
                     bus.busy, bus.done, bus.tour_len, bus.tour_valid, bus.dup_city, state_dbg);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc;
        bit ok, busy_ok;
        logic [RW-1:0] exp;
        set_identity();
        apply();
        exp_q.push_back(model_result());
        start_and_wait(cyc, ok, busy_ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || cyc != 65) $display("FAIL identity_latency: got ok=%b cycles=%0d required 65", ok, cyc);
        else n_pass++;
        n_checks++;
        if (!busy_ok) $display("FAIL identity_busy: got busy gap/late, required busy=1 before done and 0 at done");
        else n_pass++;
        n_checks++;
        if (observed() !== exp) $display("FAIL identity_result: got %h required %h", observed(), exp);
        else n_pass++;
        n_checks++;
        if (bus.tour_len !== 16'd252) $display("FAIL identity_len: got %0d required 252", bus.tour_len);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL identity_done_pulse: got done=%b one cycle later required 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_dup();
        int cyc;
        bit ok, busy_ok;
        logic [RW-1:0] exp;
        set_identity();
        m_p[6] = 5;
        apply();
        exp_q.push_back(model_result());
        start_and_wait(cyc, ok, busy_ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || observed() !== exp) $display("FAIL dup_result: got ok=%b %h required %h", ok, observed(), exp);
        else n_pass++;
        n_checks++;
        if (bus.tour_valid !== 1'b0 || bus.dup_city !== 6'd5)
            $display("FAIL dup_city: got valid=%b dup=%0d required valid=0 dup=5", bus.tour_valid, bus.dup_city);
        else n_pass++;
    endtask

    task automatic test_worst();
        int cyc;
        bit ok, busy_ok;
        for (int i = 0; i < N; i++) begin
            m_x[i] = (i % 2 == 1) ? 255 : 0;
            m_y[i] = m_x[i];
            m_p[i] = i;
        end
        apply();
        start_and_wait(cyc, ok, busy_ok);
        n_checks++;
        if (!ok || bus.tour_len !== 16'd32640 || bus.tour_valid !== 1'b1)
            $display("FAIL worst_len: got ok=%b len=%0d valid=%b required len=32640 valid=1", ok, bus.tour_len, bus.tour_valid);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        int cyc;
        int extra;
        bit ok;
        set_identity();
        apply();
        exp_q.push_back(model_result());
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        ok = 1'b0;
        while (cyc < BUDGET) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (cyc == 3) begin
                for (int i = 0; i < N; i++) begin
                    bus.path[i] = IDXW'(N - 1 - i);
                    bus.xs[i]   = COORDW'($urandom_range(0, 255));
                end
            end
            bus.start = (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (!ok || observed() !== exp_q[0])
            $display("FAIL snapshot_result: got ok=%b %h required %h", ok, observed(), exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL busy_start_ignored: got %0d extra done pulses required 0", extra);
        else n_pass++;
    endtask

    task automatic test_held_start();
        int cyc;
        int gap;
        bit ok, busy_ok;
        set_random(1'b0);
        apply();
        @(negedge clk);
        bus.start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        gap = 0;
        busy_ok = 1'b0;
        while (gap < BUDGET) begin
            @(negedge clk);
            gap++;
            if (bus.done) begin
                busy_ok = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (!ok || !busy_ok || cyc != 66 || gap != 66)
            $display("FAIL held_start_retrigger: got first=%0d gap=%0d required 66 and 66", cyc, gap);
        else n_pass++;
        n_checks++;
        if (observed() !== model_result()) $display("FAIL held_start_result: got %h required %h", observed(), model_result());
        else n_pass++;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int extra;
        bit ok, busy_ok;
        set_random(1'b0);
        apply();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.tour_len, bus.tour_valid, bus.dup_city} !== '0)
            $display("FAIL reset_mid_outputs: got busy=%b done=%b len=%0d valid=%b dup=%0d required all 0",
                     bus.busy, bus.done, bus.tour_len, bus.tour_valid, bus.dup_city);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL reset_mid_no_done: got %0d done pulses required 0", extra);
        else n_pass++;
        set_random(1'b1);
        apply();
        exp_q.push_back(model_result());
        start_and_wait(cyc, ok, busy_ok);
        n_checks++;
        if (!ok || observed() !== exp_q[0]) $display("FAIL reset_mid_recover: got ok=%b %h required %h", ok, observed(), exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        int cyc;
        bit ok, busy_ok;
        logic [RW-1:0] exp;
        for (int it = 0; it < 20; it++) begin
            set_random(it % 2 == 1);
            apply();
            exp_q.push_back(model_result());
            start_and_wait(cyc, ok, busy_ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || cyc != 65 || !busy_ok || observed() !== exp)
                $display("FAIL random_%0d: got ok=%b cycles=%0d busy_ok=%b %h required 65 cycles %h",
                         it, ok, cyc, busy_ok, observed(), exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_dup();
        test_worst();
        test_snapshot();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
